io_bus_arbiter: RTL



---
 rtl/psx_io_arb_pkg.sv | 19 +
 rtl/io_arb_watchdog.sv | 37 +++
 rtl/io_bus_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/psx_io_arb_pkg.sv
// Shared types and constants for the CPU/DMA I/O port arbiter.
package psx_io_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      RESP,
      DONE,
      RELEASE
   } arb_state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_t;

   localparam logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/io_arb_watchdog.sv
// ISSUE-phase cycle counter; flags an abort when the slave never acks.
module io_arb_watchdog #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start_i,
   input  logic run_i,
   input  logic ack_i,
   output logic expire_o
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // An ack arriving on the final cycle still wins over the abort.
   assign expire_o = run_i & ~ack_i & (cnt_q == CW'(TIMEOUT_CYCLES));

   always_comb begin
      cnt_d = cnt_q;
      if (start_i) begin
         cnt_d = '0;
      end else if (run_i && (cnt_q != CW'(TIMEOUT_CYCLES))) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/io_bus_arbiter.sv
// CPU/DMA arbiter for the shared I/O register port; DMA priority with a burst limit.
// Optional ISSUE timeout with sticky error flag is enabled by IO_ARB_TIMEOUT_EN.
module io_bus_arbiter
   import psx_io_arb_pkg::*;
#(
   parameter int DMA_BURST_MAX  = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_data_i,
   input  logic        cpu_ren,
   input  logic        cpu_wen,
   input  logic [3:0]  cpu_ben,
   output logic        cpu_ack,
   output logic [31:0] cpu_data_o,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_data_i,
   input  logic        dma_ren,
   input  logic        dma_wen,
   input  logic [3:0]  dma_ben,
   output logic        dma_ack,
   output logic [31:0] dma_data_o,
   output logic [31:0] io_addr,
   output logic [31:0] io_data_o,
   output logic [3:0]  io_ben,
   output logic        io_ren,
   output logic        io_wen,
   input  logic        io_ack,
   input  logic [31:0] io_data_i,
   output logic        owner,
   output logic        busy,
   output logic        timeout_err,
   input  logic        err_clr
);

   localparam logic [3:0] BURST_LIMIT = 4'(DMA_BURST_MAX);

   arb_state_t  state_q, state_d;
   owner_t      owner_q, owner_d;
   logic        read_q, read_d;
   logic [31:0] rdata_q, rdata_d;
   logic [3:0]  streak_q, streak_d;

   logic cpu_req, dma_req, own_req, in_issue;
   logic expire, aborted;

   assign cpu_req  = cpu_ren | cpu_wen;
   assign dma_req  = dma_ren | dma_wen;
   assign own_req  = (owner_q == OWN_DMA) ? dma_req : cpu_req;
   assign in_issue = (state_q == ISSUE);

`ifdef IO_ARB_TIMEOUT_EN
   logic aborted_q, timeout_err_q;

   io_arb_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (state_q != ISSUE),
      .run_i   (in_issue),
      .ack_i   (io_ack),
      .expire_o(expire)
   );

   // aborted_q keeps RESP from overwriting the timeout data with slave garbage.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         aborted_q     <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         if (expire) begin
            aborted_q <= 1'b1;
         end else if (state_q == IDLE) begin
            aborted_q <= 1'b0;
         end
         if (expire) begin
            timeout_err_q <= 1'b1;
         end else if (err_clr) begin
            timeout_err_q <= 1'b0;
         end
      end
   end

   assign aborted     = aborted_q;
   assign timeout_err = timeout_err_q;
`else
   logic unused_timeout;
   assign unused_timeout = err_clr | (TIMEOUT_CYCLES == 0);
   assign expire         = 1'b0;
   assign aborted        = 1'b0;
   assign timeout_err    = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      read_d   = read_q;
      rdata_d  = rdata_q;
      streak_d = streak_q;
      unique case (state_q)
         IDLE: begin
            if (dma_req && !(cpu_req && (streak_q == BURST_LIMIT))) begin
               owner_d = OWN_DMA;
               read_d  = dma_ren;
               state_d = ISSUE;
               if (cpu_req && (streak_q != BURST_LIMIT)) begin
                  streak_d = streak_q + 4'd1;
               end
            end else if (cpu_req) begin
               owner_d  = OWN_CPU;
               read_d   = cpu_ren;
               state_d  = ISSUE;
               streak_d = 4'd0;
            end
            if (!cpu_req) begin
               streak_d = 4'd0;
            end
         end
         ISSUE: begin
            if (io_ack) begin
               state_d = RESP;
            end else if (expire) begin
               state_d = RESP;
               rdata_d = TIMEOUT_DATA;
            end
         end
         RESP: begin
            if (read_q && !aborted) begin
               rdata_d = io_data_i;
            end
            state_d = DONE;
         end
         DONE: begin
            state_d = RELEASE;
         end
         RELEASE: begin
            if (!own_req) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         owner_q  <= OWN_CPU;
         read_q   <= 1'b0;
         rdata_q  <= '0;
         streak_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         read_q   <= read_d;
         rdata_q  <= rdata_d;
         streak_q <= streak_d;
      end
   end

   // Port signals are forced to zero outside ISSUE so the slave never sees stale requests.
   assign io_ren     = in_issue & read_q;
   assign io_wen     = in_issue & ~read_q;
   assign io_addr    = in_issue ? ((owner_q == OWN_DMA) ? dma_addr   : cpu_addr)   : '0;
   assign io_data_o  = in_issue ? ((owner_q == OWN_DMA) ? dma_data_i : cpu_data_i) : '0;
   assign io_ben     = in_issue ? ((owner_q == OWN_DMA) ? dma_ben    : cpu_ben)    : '0;
   assign cpu_ack    = (state_q == DONE) && (owner_q == OWN_CPU);
   assign dma_ack    = (state_q == DONE) && (owner_q == OWN_DMA);
   assign cpu_data_o = rdata_q;
   assign dma_data_o = rdata_q;
   assign owner      = owner_q;
   assign busy       = (state_q != IDLE);

endmodule
